// File: rtl/timer_pkg.sv
// Shared register map, CTRL field layout and FSM encoding for the bus timer.
package timer_pkg;

    localparam int CTRL_W = 4;

    localparam logic [1:0] TIMER_CTRL   = 2'b00;
    localparam logic [1:0] TIMER_PRESET = 2'b01;
    localparam logic [1:0] TIMER_COUNT  = 2'b10;

    localparam int EN_BIT   = 0;
    localparam int MODE_LSB = 1;
    localparam int IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        CNT  = 2'b10,
        INT  = 2'b11
    } timer_state_e;

    // Mode 1x is deliberately folded into one-shot.
    function automatic logic is_reload(input logic [CTRL_W-1:0] ctrl);
        return ctrl[MODE_LSB +: 2] == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// Programmable down-counting timer on the processor bus; one-shot or
// auto-reload, with a maskable interrupt flag feeding one HWInt line.
module timer_dev
    import timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int OFF_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic [OFF_W-1:0] PrAddr,
    input  logic             PrWE,
    input  logic [3:0]       PrBE,
    input  logic [31:0]      PrWD,
    output logic [31:0]      PrRD,
    output logic             irq
);

    logic [CTRL_W-1:0] ctrl_reg;
    logic [CNT_W-1:0]  preset_reg;
    logic [CNT_W-1:0]  count_reg;
    timer_state_e      state_reg;
    logic              int_flag_reg;

    logic [1:0]        reg_sel;
    logic              wr_en;
    logic              wr_ctrl;
    logic              wr_preset;
    logic [31:0]       rd_data;

    assign reg_sel   = PrAddr[3:2];
    assign wr_en     = sel && PrWE && (PrBE == 4'hF) && (PrAddr[1:0] == 2'b00);
    assign wr_ctrl   = wr_en && (reg_sel == TIMER_CTRL);
    assign wr_preset = wr_en && (reg_sel == TIMER_PRESET);

    always_comb begin
        rd_data = '0;
        if (sel) begin
            case (reg_sel)
                TIMER_CTRL:   rd_data[CTRL_W-1:0] = ctrl_reg;
                TIMER_PRESET: rd_data[CNT_W-1:0]  = preset_reg;
                TIMER_COUNT:  rd_data[CNT_W-1:0]  = count_reg;
                default:      rd_data = '0;
            endcase
        end
    end

    assign PrRD = rd_data;
    assign irq  = int_flag_reg & ctrl_reg[IM_BIT];

    // Register file and FSM share one process so that a software CTRL write
    // can override the hardware EN clear and the flag set in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_reg     <= {1'b0, MODE_ONESHOT, 1'b0};
            preset_reg   <= '0;
            count_reg    <= '0;
            state_reg    <= IDLE;
            int_flag_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ctrl_reg[EN_BIT]) begin
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    count_reg <= preset_reg;
                    state_reg <= CNT;
                end
                CNT: begin
                    if (!ctrl_reg[EN_BIT]) begin
                        state_reg <= IDLE;
                    end else if (count_reg > CNT_W'(1)) begin
                        count_reg <= count_reg - CNT_W'(1);
                    end else begin
                        // Flag rises on entry so it is high during the INT cycle.
                        count_reg    <= '0;
                        state_reg    <= INT;
                        int_flag_reg <= 1'b1;
                    end
                end
                INT: begin
                    if (is_reload(ctrl_reg)) begin
                        int_flag_reg <= 1'b0;
                        state_reg    <= LOAD;
                    end else begin
                        ctrl_reg[EN_BIT] <= 1'b0;
                        state_reg        <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Any CTRL write acknowledges the interrupt, whatever the data.
            if (wr_ctrl) begin
                ctrl_reg     <= PrWD[CTRL_W-1:0];
                int_flag_reg <= 1'b0;
            end
            if (wr_preset) begin
                preset_reg <= PrWD[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: register access, one-shot, auto-reload,
// masking, pause/resume, INT-cycle collision and asynchronous reset.
`timescale 1ns/1ps
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [3:0]  PrAddr;
    logic        PrWE;
    logic [3:0]  PrBE;
    logic [31:0] PrWD;
    logic [31:0] PrRD;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    timer_dev #(.CNT_W(32), .OFF_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .PrAddr (PrAddr),
        .PrWE   (PrWE),
        .PrBE   (PrBE),
        .PrWD   (PrWD),
        .PrRD   (PrRD),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write is sampled on the first rising edge after the call; returns 1ns later.
    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        sel = 1'b1; PrWE = 1'b1; PrAddr = addr; PrWD = data; PrBE = be;
        @(posedge clk);
        #1;
        sel = 1'b0; PrWE = 1'b0; PrBE = 4'h0;
        $display("wr addr=0x%0h data=0x%0h be=0x%0h", addr, data, be);
    endtask

    task automatic bus_read(input logic [3:0] addr, input logic sel_v, output logic [31:0] data);
        sel = sel_v; PrWE = 1'b0; PrAddr = addr;
        #1;
        data = PrRD;
        sel = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(addr, 1'b1, d);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        int first;
        bit found;

        reset = 1'b0; sel = 1'b0; PrWE = 1'b0; PrAddr = 4'h0; PrBE = 4'h0; PrWD = '0;
        #1;
        check("rst_irq", {31'b0, irq}, 32'h0);
        rd_check("rst_ctrl", 4'h0, 32'h0);
        rd_check("rst_preset", 4'h4, 32'h0);
        rd_check("rst_count", 4'h8, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick(1);

        // One-shot, N=5: irq on the 7th edge after the CTRL write, held.
        bus_write(4'h4, 32'd5, 4'hF);
        bus_write(4'h0, 32'h9, 4'hF);
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (irq && first == 0) first = k;
        end
        check("os_rise_cycle", first, 7);
        check("os_irq_held", {31'b0, irq}, 32'h1);
        rd_check("os_ctrl", 4'h0, 32'h8);
        rd_check("os_count", 4'h8, 32'h0);
        bus_write(4'h0, 32'h0, 4'hF);
        check("os_ack", {31'b0, irq}, 32'h0);

        // Auto-reload, N=3: period 5, COUNT 3,2,1,0 between pulses.
        bus_write(4'h4, 32'd3, 4'hF);
        bus_write(4'h0, 32'hB, 4'hF);
        for (int t = 1; t <= 20; t++) begin
            int m;
            tick(1);
            m = t % 5;
            check($sformatf("ar_irq_t%0d", t), {31'b0, irq}, (m == 0) ? 32'h1 : 32'h0);
            rd_check($sformatf("ar_cnt_t%0d", t), 4'h8, (m >= 2) ? 32'(5 - m) : 32'h0);
        end
        bus_write(4'h0, 32'h0, 4'hF);

        // Masked one-shot: counter still expires, irq stays low.
        bus_write(4'h4, 32'd2, 4'hF);
        bus_write(4'h0, 32'h1, 4'hF);
        tick(2);
        rd_check("mask_count_run", 4'h8, 32'd2);
        for (int k = 3; k <= 6; k++) begin
            tick(1);
            check($sformatf("mask_irq_t%0d", k), {31'b0, irq}, 32'h0);
        end
        rd_check("mask_expired_ctrl", 4'h0, 32'h0);

        // PRESET 0 behaves like 1: INT two edges after LOAD.
        bus_write(4'h4, 32'd0, 4'hF);
        bus_write(4'h0, 32'h9, 4'hF);
        first = 0;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (irq && first == 0) first = k;
        end
        check("p0_rise_cycle", first, 3);
        bus_write(4'h0, 32'h0, 4'hF);

        // Write qualification and read decode.
        bus_write(4'h4, 32'h1234, 4'hF);
        bus_write(4'h4, 32'hFFFF, 4'h3);
        rd_check("be_partial", 4'h4, 32'h1234);
        bus_write(4'h5, 32'h5555, 4'hF);
        rd_check("misaligned_wr", 4'h4, 32'h1234);
        rd_check("offset_c_read", 4'hC, 32'h0);
        bus_read(4'h4, 1'b0, d);
        check("unselected_read", d, 32'h0);

        // Pause at COUNT=12, then re-enable reloads from PRESET.
        bus_write(4'h4, 32'd20, 4'hF);
        bus_write(4'h0, 32'h1, 4'hF);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            bus_read(4'h8, 1'b1, d);
            if (d == 32'd13) found = 1'b1;
            else tick(1);
        end
        check("pause_reach13", {31'b0, found}, 32'h1);
        bus_write(4'h0, 32'h0, 4'hF);
        tick(3);
        rd_check("pause_hold", 4'h8, 32'd12);
        bus_write(4'h8, 32'hABCD, 4'hF);
        tick(2);
        rd_check("count_ro", 4'h8, 32'd12);
        bus_write(4'h0, 32'h1, 4'hF);
        tick(1);
        rd_check("resume_load_state", 4'h8, 32'd12);
        tick(1);
        rd_check("resume_reload", 4'h8, 32'd20);
        bus_write(4'h4, 32'd7, 4'hF);
        rd_check("preset_mid_cnt", 4'h8, 32'd19);
        tick(1);
        rd_check("preset_mid_cnt2", 4'h8, 32'd18);
        bus_write(4'h0, 32'h0, 4'hF);

        // CTRL write landing in the one-shot INT cycle.
        bus_write(4'h4, 32'd2, 4'hF);
        bus_write(4'h0, 32'h9, 4'hF);
        tick(4);
        check("coll_int_irq", {31'b0, irq}, 32'h1);
        bus_write(4'h0, 32'h9, 4'hF);
        check("coll_flag_clr", {31'b0, irq}, 32'h0);
        rd_check("coll_ctrl", 4'h0, 32'h9);
        tick(2);
        rd_check("coll_reload", 4'h8, 32'd2);
        tick(2);
        check("coll_second_int", {31'b0, irq}, 32'h1);
        bus_write(4'h0, 32'h0, 4'hF);

        // Asynchronous reset in the middle of a count.
        bus_write(4'h4, 32'd10, 4'hF);
        bus_write(4'h0, 32'h9, 4'hF);
        tick(5);
        rd_check("pre_rst_count", 4'h8, 32'd7);
        #1;
        reset = 1'b0;
        #1;
        check("arst_irq", {31'b0, irq}, 32'h0);
        rd_check("arst_ctrl", 4'h0, 32'h0);
        rd_check("arst_preset", 4'h4, 32'h0);
        rd_check("arst_count", 4'h8, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick(5);
        rd_check("post_rst_count", 4'h8, 32'h0);
        rd_check("post_rst_ctrl", 4'h0, 32'h0);
        check("post_rst_irq", {31'b0, irq}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
